mips_multi_cycle: RTL and testbench



---
 rtl/mips16_pkg.sv | 42 ++++
 rtl/mips16_alu.sv | 25 ++
 rtl/mips_multi_cycle.sv | 187 ++++++++++++++++++
 tb/tb_mips_multi_cycle.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// Shared encodings for the multi-cycle 16-bit-instruction MIPS core:
// opcodes, FSM states, ALU operations and instruction field positions.
package mips16_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LW   = 4'h3;
    localparam logic [3:0] OP_SW   = 4'h4;
    localparam logic [3:0] OP_J    = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_AND  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_OR  = 3'd3,
        ALU_AND = 3'd4
    } alu_op_t;

    // Instruction word: [15:12] op, [11:8] f1, [7:4] f2, [3:0] f3
    localparam int FIELD_W = 4;
    localparam int OP_LSB  = 12;
    localparam int F1_LSB  = 8;
    localparam int F2_LSB  = 4;
    localparam int F3_LSB  = 0;

endpackage

// File: rtl/mips16_alu.sv
// Combinational ALU for the multi-cycle core; all results wrap modulo 2^DATA_W.
module mips16_alu
    import mips16_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_XOR: y = a ^ b;
            ALU_OR:  y = a | b;
            ALU_AND: y = a & b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS-style core: loadable IMEM, register file with hardwired r0,
// and a req/ack data-memory port that tolerates any number of wait states.
module mips_multi_cycle
    import mips16_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_CNT    = 16,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_AW    = 6,
    localparam int IMEM_AW   = $clog2(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               prog_we,
    input  logic [IMEM_AW-1:0] prog_addr,
    input  logic [15:0]        prog_data,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic [DATA_W-1:0]  alu_out,
    output logic [IMEM_AW-1:0] pc,
    output logic [2:0]         state,
    output logic               halted
);

    localparam int RA_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

    logic [15:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] regs [REG_CNT];

    state_t            fsm;
    logic [15:0]       ir;
    logic [DATA_W-1:0] a_q, b_q, mdr;

    logic [3:0]         op, f1, f2, f3, idx_a, idx_b;
    logic [DATA_W-1:0]  rd_a, rd_b, imm, alu_b, alu_y;
    alu_op_t            alu_op;
    logic               use_imm, alu_wr, wb_en;
    logic [IMEM_AW-1:0] pc_next, pc_branch, pc_jump;

    assign op    = ir[OP_LSB +: FIELD_W];
    assign f1    = ir[F1_LSB +: FIELD_W];
    assign f2    = ir[F2_LSB +: FIELD_W];
    assign f3    = ir[F3_LSB +: FIELD_W];
    assign state = fsm;

    // BEQ reads (f1, f2) and SW reads its data register from f1.
    assign idx_a = (op == OP_BEQ) ? f1 : f2;
    assign idx_b = (op == OP_BEQ) ? f2 : ((op == OP_SW) ? f1 : f3);

    assign rd_a = (int'(idx_a) < REG_CNT) ? regs[idx_a[RA_W-1:0]] : '0;
    assign rd_b = (int'(idx_b) < REG_CNT) ? regs[idx_b[RA_W-1:0]] : '0;
    assign wb_en = (f1 != 4'd0) && (int'(f1) < REG_CNT);

    assign imm       = DATA_W'($signed(f3));
    assign alu_b     = use_imm ? imm : b_q;
    assign pc_next   = pc + IMEM_AW'(1);
    assign pc_branch = pc_next + IMEM_AW'($signed(f3));
    assign pc_jump   = IMEM_AW'(ir[11:0]);

    // alu_wr marks the ops whose result lands in alu_out; control-flow ops leave it alone.
    always_comb begin
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        alu_wr  = 1'b0;
        case (op)
            OP_ADD:  alu_wr = 1'b1;
            OP_SUB:  begin alu_op = ALU_SUB; alu_wr = 1'b1; end
            OP_XOR:  begin alu_op = ALU_XOR; alu_wr = 1'b1; end
            OP_OR:   begin alu_op = ALU_OR;  alu_wr = 1'b1; end
            OP_AND:  begin alu_op = ALU_AND; alu_wr = 1'b1; end
            OP_ADDI, OP_LW, OP_SW: begin use_imm = 1'b1; alu_wr = 1'b1; end
            default: ;
        endcase
    end

    mips16_alu #(.DATA_W(DATA_W)) u_alu (
        .op (alu_op),
        .a  (a_q),
        .b  (alu_b),
        .y  (alu_y)
    );

    // Program storage survives reset so a loaded image can be rerun.
    always_ff @(posedge clk) begin
        if (prog_we && (fsm == S_IDLE || fsm == S_HALTED))
            imem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= S_IDLE;
            pc         <= '0;
            alu_out    <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            halted     <= 1'b0;
            ir         <= '0;
            a_q        <= '0;
            b_q        <= '0;
            mdr        <= '0;
            for (int i = 0; i < REG_CNT; i++)
                regs[i] <= DATA_W'(i);
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (run)
                        fsm <= S_FETCH;
                end
                S_FETCH: begin
                    ir  <= imem[pc];
                    fsm <= S_DECODE;
                end
                S_DECODE: begin
                    a_q <= rd_a;
                    b_q <= rd_b;
                    fsm <= S_EXEC;
                end
                S_EXEC: begin
                    if (alu_wr)
                        alu_out <= alu_y;
                    case (op)
                        OP_J: begin
                            pc  <= pc_jump;
                            fsm <= S_FETCH;
                        end
                        OP_BEQ: begin
                            pc  <= (a_q == b_q) ? pc_branch : pc_next;
                            fsm <= S_FETCH;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            fsm    <= S_HALTED;
                        end
                        OP_LW, OP_SW: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == OP_SW);
                            dmem_addr  <= DMEM_AW'(alu_y);
                            dmem_wdata <= b_q;
                            fsm        <= S_MEM;
                        end
                        OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_ADDI:
                            fsm <= S_WB;
                        default: begin
                            pc  <= pc_next;
                            fsm <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (op == OP_LW) begin
                            mdr <= dmem_rdata;
                            fsm <= S_WB;
                        end else begin
                            pc  <= pc_next;
                            fsm <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (wb_en)
                        regs[f1[RA_W-1:0]] <= (op == OP_LW) ? mdr : alu_out;
                    pc  <= pc_next;
                    fsm <= S_FETCH;
                end
                S_HALTED: begin
                    if (run) begin
                        pc     <= '0;
                        halted <= 1'b0;
                        fsm    <= S_FETCH;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multi_cycle.sv
// Scoreboard bench for mips_multi_cycle: directed programs push expected
// fetch PCs, write-back results, memory requests and halt state; a monitor checks them.
module tb_mips_multi_cycle;
    import mips16_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        dmem_req, dmem_we;
    logic [5:0]  dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic [15:0] alu_out;
    logic [3:0]  pc;
    logic [2:0]  state;
    logic        halted;

    mips_multi_cycle dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .alu_out    (alu_out),
        .pc         (pc),
        .state      (state),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct {logic [3:0] pc; int delta;} fetch_exp_t;
    typedef struct {logic [5:0] addr; logic we; logic [15:0] wdata; int hold;} mem_exp_t;
    typedef struct {logic [3:0] pc; logic [15:0] alu;} halt_exp_t;

    fetch_exp_t  fetch_q[$];
    logic [15:0] wb_q[$];
    mem_exp_t    mem_q[$];
    halt_exp_t   halt_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: acks after resp_wait extra cycles, or follows force_ack when disabled.
    int          resp_wait = 0;
    logic        resp_en = 1'b1;
    logic        force_ack = 1'b0;
    logic [15:0] resp_data = '0;
    int          wcnt = 0;

    always begin
        @(posedge clk);
        #2;
        if (!resp_en) begin
            dmem_ack = force_ack;
            wcnt = 0;
        end else if (dmem_ack) begin
            dmem_ack = 1'b0;
            wcnt = 0;
        end else if (dmem_req) begin
            if (wcnt >= resp_wait) begin
                dmem_ack   = 1'b1;
                dmem_rdata = resp_data;
            end else begin
                wcnt++;
            end
        end
    end

    // Monitor
    logic       rst_d = 1'b1;
    logic [2:0] prev_st = 3'd0;
    int         cyc = 0;
    int         last_fetch = 0;
    int         req_cycles = 0;
    fetch_exp_t fe;
    halt_exp_t  he;

    always @(posedge clk) rst_d <= rst;

    always @(negedge clk) begin
        cyc++;
        if (rst_d) begin
            chk("rst_state", state, S_IDLE);
            chk("rst_pc", pc, 0);
            chk("rst_alu_out", alu_out, 0);
            chk("rst_req", dmem_req, 0);
            chk("rst_we", dmem_we, 0);
            chk("rst_addr", dmem_addr, 0);
            chk("rst_wdata", dmem_wdata, 0);
            chk("rst_halted", halted, 0);
            req_cycles = 0;
        end else begin
            if (state == S_FETCH && fetch_q.size() > 0) begin
                fe = fetch_q.pop_front();
                chk("fetch_pc", pc, fe.pc);
                if (fe.delta > 0)
                    chk("fetch_gap", cyc - last_fetch, fe.delta);
            end
            if (state == S_FETCH)
                last_fetch = cyc;
            if (state == S_WB && wb_q.size() > 0)
                chk("wb_alu_out", alu_out, wb_q.pop_front());
            if (state == S_HALTED && prev_st != S_HALTED && halt_q.size() > 0) begin
                he = halt_q.pop_front();
                chk("halt_flag", halted, 1);
                chk("halt_pc", pc, he.pc);
                chk("halt_alu_out", alu_out, he.alu);
            end
            if (dmem_req && mem_q.size() > 0) begin
                req_cycles++;
                chk("mem_addr", dmem_addr, mem_q[0].addr);
                chk("mem_we", dmem_we, mem_q[0].we);
                if (mem_q[0].we)
                    chk("mem_wdata", dmem_wdata, mem_q[0].wdata);
                if (dmem_ack) begin
                    chk("mem_req_cycles", req_cycles, mem_q[0].hold);
                    void'(mem_q.pop_front());
                    req_cycles = 0;
                end
            end
        end
        prev_st = state;
    end

    // Stimulus helpers
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic load_word(input int addr, input logic [15:0] data);
        prog_we   = 1'b1;
        prog_addr = 4'(addr);
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic exp_fetch(input int p, input int delta);
        fetch_exp_t e;
        e.pc = 4'(p);
        e.delta = delta;
        fetch_q.push_back(e);
    endtask

    task automatic exp_mem(input int addr, input logic we, input logic [15:0] wdata, input int hold);
        mem_exp_t e;
        e.addr = 6'(addr);
        e.we = we;
        e.wdata = wdata;
        e.hold = hold;
        mem_q.push_back(e);
    endtask

    task automatic exp_halt(input int p, input logic [15:0] alu);
        halt_exp_t e;
        e.pc = 4'(p);
        e.alu = alu;
        halt_q.push_back(e);
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n = 0;
        while (!(halted && state == S_HALTED) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_halt_reached"}, halted, 1);
        tick(2);
    endtask

    task automatic check_drained(input string name);
        chk({name, "_fetch_left"}, fetch_q.size(), 0);
        chk({name, "_wb_left"}, wb_q.size(), 0);
        chk({name, "_mem_left"}, mem_q.size(), 0);
        chk({name, "_halt_left"}, halt_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        do_reset();

        // ADD r4,r1,r2 ; HALT
        load_word(0, 16'h0412);
        load_word(1, 16'hF000);
        exp_fetch(0, 0); exp_fetch(1, 4);
        wb_q.push_back(16'h0003);
        exp_halt(1, 16'h0003);
        pulse_run();
        wait_halt("add", 50);
        check_drained("add");

        // LW with two wait states, then forward the loaded value
        do_reset();
        load_word(0, 16'h3512);
        load_word(1, 16'h0650);
        load_word(2, 16'hF000);
        resp_wait = 2;
        resp_data = 16'hBEEF;
        exp_fetch(0, 0); exp_fetch(1, 7); exp_fetch(2, 4);
        exp_mem(3, 1'b0, 16'h0000, 3);
        wb_q.push_back(16'h0003);
        wb_q.push_back(16'hBEEF);
        exp_halt(2, 16'hBEEF);
        pulse_run();
        wait_halt("lw", 60);
        check_drained("lw");

        // BEQ taken, then not taken after patching word 0 while halted
        do_reset();
        load_word(0, 16'h8112);
        load_word(1, 16'h2011);
        load_word(2, 16'h2011);
        load_word(3, 16'h2713);
        load_word(4, 16'hF000);
        exp_fetch(0, 0); exp_fetch(3, 3); exp_fetch(4, 4);
        wb_q.push_back(16'h0004);
        exp_halt(4, 16'h0004);
        pulse_run();
        wait_halt("beq_taken", 50);
        check_drained("beq_taken");

        load_word(0, 16'h8122);
        exp_fetch(0, 0); exp_fetch(1, 3); exp_fetch(2, 4); exp_fetch(3, 4); exp_fetch(4, 4);
        wb_q.push_back(16'h0002);
        wb_q.push_back(16'h0002);
        wb_q.push_back(16'h0004);
        exp_halt(4, 16'h0004);
        pulse_run();
        wait_halt("beq_not_taken", 60);
        check_drained("beq_not_taken");

        // r0 hardwiring, SUB wrap, logic ops, J, forward and backward branches
        do_reset();
        load_word(0, 16'h2015);
        load_word(1, 16'h0700);
        load_word(2, 16'h1412);
        load_word(3, 16'h6853);
        load_word(4, 16'h795A);
        load_word(5, 16'h9BD6);
        load_word(6, 16'h5009);
        load_word(9, 16'h8002);
        load_word(11, 16'hF000);
        load_word(12, 16'h800E);
        exp_fetch(0, 0); exp_fetch(1, 4); exp_fetch(2, 4); exp_fetch(3, 4);
        exp_fetch(4, 4); exp_fetch(5, 4); exp_fetch(6, 4); exp_fetch(9, 3);
        exp_fetch(12, 3); exp_fetch(11, 3);
        wb_q.push_back(16'h0006);
        wb_q.push_back(16'h0000);
        wb_q.push_back(16'hFFFF);
        wb_q.push_back(16'h0006);
        wb_q.push_back(16'h000F);
        wb_q.push_back(16'h0004);
        exp_halt(11, 16'h0004);
        pulse_run();
        wait_halt("alu_mix", 100);
        check_drained("alu_mix");

        // SW with zero-wait ack
        do_reset();
        load_word(0, 16'h4312);
        load_word(1, 16'hF000);
        resp_wait = 0;
        exp_fetch(0, 0); exp_fetch(1, 4);
        exp_mem(3, 1'b1, 16'h0003, 1);
        exp_halt(1, 16'h0003);
        pulse_run();
        wait_halt("sw", 50);
        check_drained("sw");

        // All-NOP image: PC walks the whole IMEM and wraps to 0, 3 cycles per step
        do_reset();
        for (int i = 0; i < 16; i++)
            load_word(i, 16'hE000);
        exp_fetch(0, 0);
        for (int k = 1; k < 18; k++)
            exp_fetch(k % 16, 3);
        pulse_run();
        begin
            int n = 0;
            while (fetch_q.size() > 0 && n < 200) begin
                tick();
                n++;
            end
        end
        tick(2);
        chk("nop_fetch_left", fetch_q.size(), 0);
        chk("nop_alu_out_kept", alu_out, 0);

        // Reset while a store is stalled; a late ack must be ignored
        do_reset();
        load_word(0, 16'h4312);
        load_word(1, 16'h0830);
        load_word(2, 16'hF000);
        resp_en = 1'b0;
        force_ack = 1'b0;
        exp_fetch(0, 0);
        exp_mem(3, 1'b1, 16'h0003, 99);
        pulse_run();
        begin
            int n = 0;
            while (state != S_MEM && n < 20) begin
                tick();
                n++;
            end
        end
        chk("stall_in_mem", state, S_MEM);
        tick(3);
        chk("stall_req_held", dmem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        mem_q.delete();
        chk("abort_fetch_left", fetch_q.size(), 0);
        force_ack = 1'b1;
        tick(2);
        force_ack = 1'b0;
        tick(2);
        chk("late_ack_state", state, S_IDLE);
        chk("late_ack_req", dmem_req, 0);
        resp_en = 1'b1;
        load_word(0, 16'h0830);
        load_word(1, 16'hF000);
        exp_fetch(0, 0); exp_fetch(1, 4);
        wb_q.push_back(16'h0003);
        exp_halt(1, 16'h0003);
        pulse_run();
        wait_halt("after_abort", 50);
        check_drained("after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
